// File: rtl/apb4_rng_fifo_pkg.sv
// rng_define: register map, bit positions and CTRL layout shared by the apb4_rng_fifo block
package rng_define;
  localparam logic [3:0] RNG_CTRL = 4'd0;
  localparam logic [3:0] RNG_PSCR = 4'd1;
  localparam logic [3:0] RNG_SEED = 4'd2;
  localparam logic [3:0] RNG_VAL  = 4'd3;
  localparam logic [3:0] RNG_STAT = 4'd4;
  localparam int CTRL_EN    = 0;
  localparam int CTRL_IE    = 1;
  localparam int CTRL_FLUSH = 2;
  localparam int CTRL_THR   = 8;
  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_IRQ   = 2;
  localparam int STAT_CNT   = 8;
  localparam int THR_MAX_W  = 7;
  typedef struct packed {
    logic [THR_MAX_W-1:0] thr;
    logic                 ie;
    logic                 en;
  } ctrl_t;
endpackage

// File: rtl/apb4_rng_fifo_if.sv
// apb4_rng_fifo_if: APB4 completer bus bundle with master/slave views
interface apb4_rng_fifo_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  modport master (output paddr, psel, penable, pwrite, pwdata, input prdata, pready, pslverr);
  modport slave (input paddr, psel, penable, pwrite, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/apb4_rng_fifo_fifo.sv
// rng_fifo: synchronous FIFO with flush, pointers carry an extra wrap bit
module rng_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  logic [W-1:0] mem [DEPTH];
  logic [CNT_W-1:0] wp, rp;
  assign count = wp - rp;
  assign full = count == CNT_W'(DEPTH);
  assign empty = wp == rp;
  assign head = mem[rp[CNT_W-2:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wp[CNT_W-2:0]] <= din;
  end
endmodule

// File: rtl/apb4_rng_fifo.sv
// apb4_rng_fifo: prescaled Galois LFSR feeding a pop-on-read FIFO behind an APB4 slave
module apb4_rng_fifo
  import rng_define::*;
#(
  parameter int          DAT_WIDTH  = 32,
  parameter logic [31:0] TAPS       = 32'hE000_0200,
  parameter int          FIFO_DEPTH = 8,
  parameter int          PSCR_WIDTH = 16
) (
  input  logic           pclk,
  input  logic           presetn,
  apb4_rng_fifo_if.slave apb,
  output logic           irq_o
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  ctrl_t ctrl;
  logic [PSCR_WIDTH-1:0] pscr, pcnt;
  logic [DAT_WIDTH-1:0] lfsr, lfsr_next, seed_val, head;
  logic [CNT_W-1:0] count;
  logic [3:0] idx;
  logic [31:0] rdata;
  logic full, empty, wr, rd, wr_ctrl, wr_seed, tick, push, pop, flush, unused;
  assign idx = apb.paddr[5:2];
  assign wr = apb.psel && apb.penable && apb.pwrite;
  assign rd = apb.psel && apb.penable && !apb.pwrite;
  assign wr_ctrl = wr && idx == RNG_CTRL;
  assign wr_seed = wr && idx == RNG_SEED;
  assign tick = ctrl.en && pcnt == pscr;
  // a full FIFO stalls the LFSR; a seed write discards the tick
  assign push = tick && !full && !wr_seed;
  assign pop = rd && idx == RNG_VAL;
  assign flush = wr_seed || (wr_ctrl && apb.pwdata[CTRL_FLUSH]);
  assign seed_val = apb.pwdata[DAT_WIDTH-1:0] == '0 ? DAT_WIDTH'(1) : apb.pwdata[DAT_WIDTH-1:0];
  assign lfsr_next = lfsr[0] ? (lfsr >> 1) ^ TAPS[DAT_WIDTH-1:0] : lfsr >> 1;
  assign apb.pready = 1'b1;
  assign apb.pslverr = 1'b0;
  assign apb.prdata = rd ? rdata : '0;
  assign unused = ^{apb.paddr[31:6], apb.paddr[1:0], apb.pwdata};
  rng_fifo #(.W(DAT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(pclk),
    .rst_n(presetn),
    .push(push),
    .pop(pop),
    .flush(flush),
    .din(lfsr),
    .head(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ctrl <= '0;
      pscr <= '0;
      pcnt <= '0;
      irq_o <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= '{thr: THR_MAX_W'(apb.pwdata[CTRL_THR +: CNT_W]), ie: apb.pwdata[CTRL_IE], en: apb.pwdata[CTRL_EN]};
      if (wr && idx == RNG_PSCR) pscr <= apb.pwdata[PSCR_WIDTH-1:0];
      pcnt <= (wr_seed || !ctrl.en || tick) ? '0 : pcnt + 1'b1;
      irq_o <= ctrl.ie && (THR_MAX_W'(count) >= ctrl.thr);
    end
  end
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) lfsr <= DAT_WIDTH'(1);
    else if (wr_seed) lfsr <= seed_val;
    else if (push) lfsr <= lfsr_next;
  end
  always_comb begin
    rdata = '0;
    case (idx)
      RNG_CTRL: begin
        rdata[CTRL_EN] = ctrl.en;
        rdata[CTRL_IE] = ctrl.ie;
        rdata[CTRL_THR +: CNT_W] = ctrl.thr[CNT_W-1:0];
      end
      RNG_PSCR: rdata[PSCR_WIDTH-1:0] = pscr;
      RNG_VAL: rdata[DAT_WIDTH-1:0] = empty ? '0 : head;
      RNG_STAT: begin
        rdata[STAT_EMPTY] = empty;
        rdata[STAT_FULL] = full;
        rdata[STAT_IRQ] = irq_o;
        rdata[STAT_CNT +: CNT_W] = count;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_apb4_rng_fifo.sv
// tb_apb4_rng_fifo: randomized APB traffic against a queue-based reference model with a read scoreboard
module tb_apb4_rng_fifo;
  localparam int DEPTH = 8;
  localparam logic [31:0] TAPS = 32'hE000_0200;
  typedef struct {
    logic [31:0] v;
    logic [3:0]  i;
  } exp_t;
  logic pclk = 1'b0;
  logic presetn = 1'b1;
  logic irq_o;
  apb4_rng_fifo_if bus ();
  apb4_rng_fifo #(.DAT_WIDTH(32), .TAPS(TAPS), .FIFO_DEPTH(DEPTH), .PSCR_WIDTH(16)) dut (
    .pclk(pclk),
    .presetn(presetn),
    .apb(bus),
    .irq_o(irq_o)
  );
  always #5 pclk = ~pclk;
  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  logic [31:0] q[$];
  logic m_en = 0, m_ie = 0, m_irq = 0;
  logic [3:0] m_thr = 0;
  logic [15:0] m_pscr = 0;
  int m_pc = 0;
  logic [31:0] m_lfsr = 32'd1;
  function automatic logic [31:0] step(input logic [31:0] v);
    return v[0] ? (v >> 1) ^ TAPS : v >> 1;
  endfunction
  function automatic logic [31:0] model_read(input logic [3:0] i);
    logic [31:0] r = 0;
    if (i == 0) begin r[0] = m_en; r[1] = m_ie; r[11:8] = m_thr; end
    if (i == 1) r[15:0] = m_pscr;
    if (i == 3 && q.size() > 0) r = q[0];
    if (i == 4) begin
      r[0] = q.size() == 0;
      r[1] = q.size() == DEPTH;
      r[2] = m_irq;
      r[11:8] = 4'(q.size());
    end
    return r;
  endfunction
  logic w, r, tk, sd, fl, fu, ps, nirq;
  logic [3:0] mi;
  // reference model: one generation every pscr+1 enabled cycles, values held in a plain queue
  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      m_en = 0; m_ie = 0; m_thr = 0; m_pscr = 0; m_pc = 0; m_lfsr = 1; m_irq = 0;
      q.delete();
    end else begin
      w = bus.psel && bus.penable && bus.pwrite;
      r = bus.psel && bus.penable && !bus.pwrite;
      mi = bus.paddr[5:2];
      tk = m_en && m_pc == int'(m_pscr);
      sd = w && mi == 2;
      fl = sd || (w && mi == 0 && bus.pwdata[2]);
      fu = q.size() == DEPTH;
      ps = tk && !fu && !sd;
      nirq = m_ie && q.size() >= int'(m_thr);
      if (fl) q.delete();
      else begin
        if (r && mi == 3 && q.size() > 0) void'(q.pop_front());
        if (ps) q.push_back(m_lfsr);
      end
      if (ps) m_lfsr = step(m_lfsr);
      m_pc = (sd || !m_en || tk) ? 0 : m_pc + 1;
      if (w && mi == 0) begin m_en = bus.pwdata[0]; m_ie = bus.pwdata[1]; m_thr = bus.pwdata[11:8]; end
      if (w && mi == 1) m_pscr = bus.pwdata[15:0];
      if (sd) m_lfsr = bus.pwdata == 0 ? 32'd1 : bus.pwdata;
      m_irq = nirq;
    end
  end
  exp_t e;
  always @(negedge pclk) begin
    if (presetn) begin
      checks++;
      if (irq_o !== m_irq) begin errors++; $display("FAIL irq_o got %0b want %0b t=%0t", irq_o, m_irq, $time); end
      if (bus.psel && bus.penable && !bus.pwrite) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rd_unexpected no expectation queued t=%0t", $time); end
        else begin
          e = exp_q.pop_front();
          if (bus.prdata !== e.v || bus.pready !== 1'b1 || bus.pslverr !== 1'b0) begin
            errors++;
            $display("FAIL rd_idx%0d got %08h want %08h rdy=%0b err=%0b t=%0t", e.i, bus.prdata, e.v, bus.pready, bus.pslverr, $time);
          end
        end
      end else begin
        checks++;
        if (bus.prdata !== 32'd0) begin errors++; $display("FAIL prdata_idle got %08h want 0 t=%0t", bus.prdata, $time); end
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) begin @(posedge pclk); #1; end
  endtask
  task automatic apb_write(input logic [3:0] i, input logic [31:0] d);
    bus.paddr = {26'd0, i, 2'd0}; bus.pwrite = 1; bus.pwdata = d; bus.psel = 1; bus.penable = 0;
    @(posedge pclk); #1 bus.penable = 1;
    @(posedge pclk); #1 bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
  endtask
  task automatic apb_read(input logic [3:0] i, input bit fix = 0, input logic [31:0] want = 0);
    exp_t x;
    bus.paddr = {26'd0, i, 2'd0}; bus.pwrite = 0; bus.psel = 1; bus.penable = 0;
    @(posedge pclk); #1 bus.penable = 1;
    x.i = i;
    x.v = fix ? want : model_read(i);
    exp_q.push_back(x);
    @(posedge pclk); #1 bus.psel = 0; bus.penable = 0;
  endtask
  task automatic async_reset();
    #2 presetn = 0;
    @(posedge pclk); #1 presetn = 1;
  endtask
  initial begin
    bus.paddr = 0; bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.pwdata = 0;
    #2 presetn = 0;
    repeat (3) @(posedge pclk);
    #1 presetn = 1;
    apb_read(0, 1, 32'h0);
    apb_read(1, 1, 32'h0);
    apb_read(2, 1, 32'h0);
    apb_read(3, 1, 32'h0);
    apb_read(4, 1, 32'h1);
    apb_read(9, 1, 32'h0);
    apb_write(2, 1); apb_write(1, 0); apb_write(0, 1);
    idle(1);
    apb_write(0, 0);
    apb_read(3, 1, 32'h0000_0001);
    apb_read(3, 1, 32'hE000_0200);
    apb_read(3, 1, 32'h7000_0100);
    apb_read(4, 1, 32'h1);
    apb_write(2, 1); apb_write(1, 3); apb_write(0, 1);
    idle(12);
    apb_write(0, 0);
    apb_read(4);
    apb_write(2, 1); apb_write(1, 0); apb_write(0, 1);
    idle(12);
    apb_write(0, 0);
    apb_read(4, 1, 32'h802);
    for (int k = 0; k < 8; k++) apb_read(3);
    apb_read(3, 1, 32'h0);
    apb_read(4, 1, 32'h1);
    apb_write(2, 1); apb_write(0, 32'h403);
    idle(8);
    apb_write(0, 32'h402);
    apb_read(4);
    for (int k = 0; k < 6; k++) apb_read(3);
    apb_write(0, 0);
    apb_write(0, 1); idle(3); apb_write(0, 0);
    apb_write(2, 0);
    apb_read(4, 1, 32'h1);
    apb_write(0, 1); apb_write(0, 0);
    apb_read(3, 1, 32'h0000_0001);
    apb_write(0, 1); idle(2);
    apb_write(0, 4);
    apb_read(4, 1, 32'h1);
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 9))
        0, 1: apb_write(0, {20'd0, 4'($urandom_range(0, 15)), 5'd0, ($urandom_range(0, 5) == 0), 1'($urandom), ($urandom_range(0, 3) != 0)});
        2: apb_write(1, $urandom_range(0, 3));
        3: apb_write(2, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
        4, 5, 6: apb_read(3);
        7: apb_read(4'($urandom_range(0, 15)));
        8: idle($urandom_range(1, 5));
        default: if (k % 50 == 9) async_reset(); else apb_read(4);
      endcase
    end
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
